// File: rtl/serial_pkg.sv
//------------------------------------------------------------------------------
// serial_pkg
// Shared types and line levels for the serial transmitter.
//   tx_state_t  : frame sequencing states (IDLE -> START -> DATA -> STOP)
//   *_LEVEL     : TXD level driven while idle, in the start bit, in the stop bit
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
//------------------------------------------------------------------------------
// bit_timer
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last count of each
// bit period.
//   CK   : clock, rising edge
//   RB   : asynchronous active-low reset
//   CLR  : holds/restarts the count at 0
//   TICK : high during the last cycle of a bit period (count == CLK_DIV-1)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic CK,
  input  logic RB,
  input  logic CLR,
  output logic TICK
);

  // A one-bit counter still exists for CLK_DIV=1; it simply stays at 0, so
  // TICK is permanently high and every cycle is a bit boundary.
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      count_reg <= '0;
    end else if (CLR || (count_reg == LAST)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign TICK = (count_reg == LAST);

endmodule

// File: rtl/serial_tx.sv
//------------------------------------------------------------------------------
// serial_tx
// Parallel-to-serial transmitter. Accepts one word per VALID/READY handshake
// and sends it as: start bit (0), DATA_W data bits LSB first, stop bit (1).
// Each bit lasts CLK_DIV cycles; the line idles high.
//   CK    : clock, rising edge
//   RB    : asynchronous active-low reset (abandons any frame in progress)
//   DIN   : word to send, captured only on the accepting edge
//   VALID : DIN is valid
//   READY : high only in IDLE (registered, no path from VALID)
//   TXD   : serial line (registered)
//   BUSY  : frame in progress (registered)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              CK,
  input  logic              RB,
  input  logic [DATA_W-1:0] DIN,
  input  logic              VALID,
  output logic              READY,
  output logic              TXD,
  output logic              BUSY
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [BW-1:0]     bit_cnt_reg;
  logic              txd_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              tick;
  logic              div_clr;
  logic              accept;

  // Divider is held at 0 while idle, so the start bit always begins a fresh
  // period. Every later state change happens on a tick, where the divider
  // wraps to 0 by itself.
  assign div_clr = (state_reg == IDLE);
  assign accept  = (state_reg == IDLE) && VALID;

  // TXD is registered, so the bit driven after a shift is taken from the
  // shifted value rather than the current register.
  assign shift_next = shift_reg >> 1;

  bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .CK   (CK),
    .RB   (RB),
    .CLR  (div_clr),
    .TICK (tick)
  );

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      txd_reg     <= IDLE_LEVEL;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg <= DIN;
            state_reg <= START;
            txd_reg   <= START_LEVEL;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
          end
        end

        START: begin
          if (tick) begin
            state_reg <= DATA;
            txd_reg   <= shift_reg[0];
          end
        end

        DATA: begin
          if (tick) begin
            shift_reg <= shift_next;
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg   <= STOP;
              txd_reg     <= STOP_LEVEL;
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              txd_reg     <= shift_next[0];
            end
          end
        end

        STOP: begin
          if (tick) begin
            state_reg <= IDLE;
            txd_reg   <= IDLE_LEVEL;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          txd_reg   <= IDLE_LEVEL;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign READY = ready_reg;
  assign TXD   = txd_reg;
  assign BUSY  = busy_reg;

endmodule
